// File: rtl/iq_pkg.sv
// Shared defaults, FSM state type and mixer phase encoding for the IQ integrator.
package iq_pkg;

  localparam int ADC_W_DEF   = 12;
  localparam int LEN_W_DEF   = 16;
  localparam int DELAY_W_DEF = 16;
  localparam int OUT_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DELAY     = 2'd1,
    INTEGRATE = 2'd2,
    OUTPUT    = 2'd3
  } iq_state_t;

  localparam logic [1:0] PH_I_POS = 2'd0;
  localparam logic [1:0] PH_Q_NEG = 2'd1;
  localparam logic [1:0] PH_I_NEG = 2'd2;
  localparam logic [1:0] PH_Q_POS = 2'd3;

endpackage

// File: rtl/iq_mixer.sv
// fs/4 digital down-mixer: maps one sample and its phase onto {+x, -x, 0}
// contributions for the I and Q accumulators.
module iq_mixer
  import iq_pkg::*;
#(
  parameter int XW = ADC_W_DEF
) (
  input  logic signed [XW-1:0] x,
  input  logic        [1:0]    phase,
  output logic signed [XW:0]   i_c,
  output logic signed [XW:0]   q_c
);

  localparam logic signed [XW:0] ZERO = {(XW + 1){1'b0}};

  logic signed [XW:0] x_ext;
  logic signed [XW:0] x_neg;

  // One extra bit so that negating the most negative sample cannot wrap.
  assign x_ext = {x[XW-1], x};
  assign x_neg = -x_ext;

  // Phase-dependent selection of the I/Q contribution.
  always_comb begin
    i_c = ZERO;
    q_c = ZERO;
    case (phase)
      PH_I_POS: i_c = x_ext;
      PH_Q_NEG: q_c = x_neg;
      PH_I_NEG: i_c = x_neg;
      PH_Q_POS: q_c = x_ext;
      default: begin
        i_c = ZERO;
        q_c = ZERO;
      end
    endcase
  end

endmodule

// File: rtl/iq_integrator.sv
// Per-shot fs/4 demodulation and boxcar integration of the ADC trace into one
// signed (I,Q) point. Optional feature macro: IQ_DC_OFFSET_EN (dc_offset port).
module iq_integrator
  import iq_pkg::*;
#(
  parameter int ADC_W   = ADC_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] trig_delay,
  input  logic [LEN_W-1:0]   int_len,
`ifdef IQ_DC_OFFSET_EN
  input  logic [ADC_W-1:0]   dc_offset,
`endif
  output logic [OUT_W-1:0]   i_val,
  output logic [OUT_W-1:0]   q_val,
  output logic               data_out,
  output logic               busy,
  output logic               overrun
);

`ifdef IQ_DC_OFFSET_EN
  localparam int XW = ADC_W + 1;
`else
  localparam int XW = ADC_W;
`endif
  localparam int ACC_W = XW + LEN_W + 1;

  localparam logic [LEN_W-1:0]   LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]   LEN_ONE  = {{(LEN_W - 1){1'b0}}, 1'b1};
  localparam logic [DELAY_W-1:0] DLY_ZERO = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0] DLY_ONE  = {{(DELAY_W - 1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0]   ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [OUT_W-1:0]   OUT_ZERO = {OUT_W{1'b0}};

  generate
    if (OUT_W < ACC_W) begin : g_out_width_check
      $error("iq_integrator: OUT_W too narrow for the accumulator width");
    end
  endgenerate

  iq_state_t                 state_q, state_d;
  logic [DELAY_W-1:0]        dly_q, dly_d;
  logic [LEN_W-1:0]          rem_q, rem_d;
  logic [1:0]                ph_q, ph_d;
  logic signed [ACC_W-1:0]   acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]   acc_q_q, acc_q_d;
  logic [OUT_W-1:0]          i_val_q, i_val_d;
  logic [OUT_W-1:0]          q_val_q, q_val_d;
  logic                      data_out_q, data_out_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;
`ifdef IQ_DC_OFFSET_EN
  logic [ADC_W-1:0]          dc_q, dc_d;
`endif

  logic signed [XW-1:0]      x_s;
  logic signed [XW:0]        mix_i_s;
  logic signed [XW:0]        mix_q_s;

`ifdef IQ_DC_OFFSET_EN
  assign x_s = $signed({adc_data[ADC_W-1], adc_data}) - $signed({dc_q[ADC_W-1], dc_q});
`else
  assign x_s = $signed(adc_data);
`endif

  iq_mixer #(
    .XW (XW)
  ) u_mixer (
    .x     (x_s),
    .phase (ph_q),
    .i_c   (mix_i_s),
    .q_c   (mix_q_s)
  );

  // Shot sequencing, accumulation and result/flag generation.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    rem_d      = rem_q;
    ph_d       = ph_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    i_val_d    = i_val_q;
    q_val_d    = q_val_q;
    data_out_d = 1'b0;
    overrun_d  = overrun_q | (trigger & (state_q != IDLE));
`ifdef IQ_DC_OFFSET_EN
    dc_d       = dc_q;
`endif

    case (state_q)
      IDLE: begin
        if (trigger) begin
          dly_d   = trig_delay;
          rem_d   = (int_len == LEN_ZERO) ? LEN_ONE : int_len;
          ph_d    = PH_I_POS;
          acc_i_d = ACC_ZERO;
          acc_q_d = ACC_ZERO;
`ifdef IQ_DC_OFFSET_EN
          dc_d    = dc_offset;
`endif
          state_d = (trig_delay == DLY_ZERO) ? INTEGRATE : DELAY;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        dly_d = dly_q - DLY_ONE;
        if (dly_q == DLY_ONE) begin
          state_d = INTEGRATE;
        end else begin
          state_d = DELAY;
        end
      end
      INTEGRATE: begin
        acc_i_d = acc_i_q + ACC_W'(mix_i_s);
        acc_q_d = acc_q_q + ACC_W'(mix_q_s);
        ph_d    = ph_q + 2'd1;
        rem_d   = rem_q - LEN_ONE;
        if (rem_q == LEN_ONE) begin
          state_d = OUTPUT;
        end else begin
          state_d = INTEGRATE;
        end
      end
      OUTPUT: begin
        i_val_d    = OUT_W'(acc_i_q);
        q_val_d    = OUT_W'(acc_q_q);
        data_out_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any shot in progress.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dly_q      <= DLY_ZERO;
      rem_q      <= LEN_ZERO;
      ph_q       <= PH_I_POS;
      acc_i_q    <= ACC_ZERO;
      acc_q_q    <= ACC_ZERO;
      i_val_q    <= OUT_ZERO;
      q_val_q    <= OUT_ZERO;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef IQ_DC_OFFSET_EN
      dc_q       <= {ADC_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      rem_q      <= rem_d;
      ph_q       <= ph_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      i_val_q    <= i_val_d;
      q_val_q    <= q_val_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
`ifdef IQ_DC_OFFSET_EN
      dc_q       <= dc_d;
`endif
    end
  end

  assign i_val    = i_val_q;
  assign q_val    = q_val_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule
